xconf_mem_ctrl: RTL and testbench



---
 rtl/xconf_mem_ctrl_pkg.sv | 20 ++
 rtl/xconf_slot_ram.sv | 22 ++
 rtl/xconf_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_xconf_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xconf_mem_ctrl_pkg.sv
// rtl/xconf_mem_ctrl_pkg.sv - shared command offsets, FSM encoding and status layout
package xconf_mem_ctrl_pkg;

  localparam logic [1:0] CMD_SAVE   = 2'd0;
  localparam logic [1:0] CMD_LOAD   = 2'd1;
  localparam logic [1:0] CMD_CLEAR  = 2'd2;
  localparam logic [1:0] CMD_STATUS = 2'd3;
  localparam int         CMD_WINDOW = 4;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;
  localparam int STAT_MAP_LSB  = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_RD  = 2'd1,
    ST_LOAD_OUT = 2'd2
  } state_t;

endpackage

// File: rtl/xconf_slot_ram.sv
// rtl/xconf_slot_ram.sv - single-port slot RAM with registered read
// Contents and output register are deliberately unreset so a technology macro can drop in.
module xconf_slot_ram #(
  parameter int CONF_BITS = 256,
  parameter int SLOT_W    = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [SLOT_W-1:0]    addr,
  input  logic [CONF_BITS-1:0] wdata,
  output logic [CONF_BITS-1:0] rdata
);

  logic [CONF_BITS-1:0] mem [2**SLOT_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/xconf_mem_ctrl.sv
// rtl/xconf_mem_ctrl.sv - save/restore controller in front of the configuration register
// Optional per-slot valid tracking and sticky load error: define CONF_MEM_VALID_EN.
module xconf_mem_ctrl
  import xconf_mem_ctrl_pkg::*;
#(
  parameter int                    CONF_BITS     = 256,
  parameter int                    SLOT_W        = 3,
  parameter int                    CTR_ADDR_W    = 10,
  parameter int                    DATA_W        = 11,
  parameter logic [CTR_ADDR_W-1:0] CONF_MEM_BASE = 10'h3F0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctr_valid,
  input  logic                  ctr_we,
  input  logic [CTR_ADDR_W-1:0] ctr_addr,
  input  logic [DATA_W-1:0]     ctr_data_in,
  output logic                  ctr_ready,
  output logic [DATA_W-1:0]     ctr_rdata,
  input  logic [CONF_BITS-1:0]  conf_cur,
  output logic [CONF_BITS-1:0]  conf_in,
  output logic                  conf_ld
);

  localparam int SLOTS = 2**SLOT_W;

  state_t                state;
  logic [SLOT_W-1:0]     slot_q;
  logic [SLOT_W-1:0]     cmd_slot;
  logic [SLOT_W-1:0]     ram_addr;
  logic [CONF_BITS-1:0]  ram_rdata;
  logic [CONF_BITS-1:0]  conf_q;
  logic                  ld_q;
  logic [CTR_ADDR_W-1:0] offset;
  logic                  hit;
  logic                  accept;
  logic                  do_save;
  logic                  do_load;
  logic                  do_status;
  logic                  load_ok;
  logic [SLOTS-1:0]      valid_w;
  logic                  err_w;
  logic [DATA_W-1:0]     status_w;
  logic                  unused_slot_bits;

  // Upper operand bits wrap the slot index modulo the slot count.
  assign cmd_slot         = ctr_data_in[SLOT_W-1:0];
  assign unused_slot_bits = ^ctr_data_in[DATA_W-1:SLOT_W];

  assign ctr_ready = (state == ST_IDLE);
  assign offset    = ctr_addr - CONF_MEM_BASE;
  assign hit       = (offset < CTR_ADDR_W'(CMD_WINDOW));
  assign accept    = ctr_valid & ctr_ready & hit;
  assign do_save   = accept &  ctr_we & (offset[1:0] == CMD_SAVE);
  assign do_load   = accept &  ctr_we & (offset[1:0] == CMD_LOAD);
  assign do_status = accept & ~ctr_we & (offset[1:0] == CMD_STATUS);

`ifdef CONF_MEM_VALID_EN
  logic             do_clear;
  logic [SLOTS-1:0] valid_q;
  logic             err_q;

  assign do_clear = accept & ctr_we & (offset[1:0] == CMD_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= 1'b0;
    end else if (do_clear) begin
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (do_save) valid_q[cmd_slot] <= 1'b1;
      if (state == ST_LOAD_RD && !valid_q[slot_q]) err_q <= 1'b1;
    end
  end

  assign valid_w = valid_q;
  assign err_w   = err_q;
  assign load_ok = valid_q[slot_q];
`else
  assign valid_w = '0;
  assign err_w   = 1'b0;
  assign load_ok = 1'b1;
`endif

  always_comb begin
    status_w                = '0;
    status_w[STAT_BUSY_BIT] = (state != ST_IDLE);
    status_w[STAT_ERR_BIT]  = err_w;
    for (int i = 0; i < SLOTS; i++) begin
      if (STAT_MAP_LSB + i < DATA_W) status_w[STAT_MAP_LSB + i] = valid_w[i];
    end
  end

  // SAVE writes in IDLE and LOAD reads only in LOAD_RD, so one port suffices.
  assign ram_addr = (state == ST_IDLE) ? cmd_slot : slot_q;

  xconf_slot_ram #(
    .CONF_BITS(CONF_BITS),
    .SLOT_W   (SLOT_W)
  ) u_slot_ram (
    .clk  (clk),
    .we   (do_save),
    .re   (state == ST_LOAD_RD),
    .addr (ram_addr),
    .wdata(conf_cur),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      slot_q    <= '0;
      ld_q      <= 1'b0;
      conf_q    <= '0;
      ctr_rdata <= '0;
    end else begin
      if (do_status) ctr_rdata <= status_w;
      case (state)
        ST_IDLE: begin
          ld_q <= 1'b0;
          if (do_load) begin
            slot_q <= cmd_slot;
            state  <= ST_LOAD_RD;
          end
        end
        ST_LOAD_RD: begin
          ld_q  <= load_ok;
          state <= ST_LOAD_OUT;
        end
        ST_LOAD_OUT: begin
          if (ld_q) conf_q <= ram_rdata;
          ld_q  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ld_q  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The RAM output register feeds conf_in directly during the strobe, then conf_q holds it.
  assign conf_ld = ld_q;
  assign conf_in = ld_q ? ram_rdata : conf_q;

endmodule

// File: tb/tb_xconf_mem_ctrl.sv
// tb/tb_xconf_mem_ctrl.sv - randomized self-checking bench for xconf_mem_ctrl
module tb_xconf_mem_ctrl;

  localparam int              CONF_BITS  = 256;
  localparam int              SLOT_W     = 3;
  localparam int              CTR_ADDR_W = 10;
  localparam int              DATA_W     = 11;
  localparam int              NSLOT      = 8;
  localparam logic [9:0]      BASE       = 10'h3F0;
`ifdef CONF_MEM_VALID_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  ctr_valid;
  logic                  ctr_we;
  logic [CTR_ADDR_W-1:0] ctr_addr;
  logic [DATA_W-1:0]     ctr_data_in;
  logic                  ctr_ready;
  logic [DATA_W-1:0]     ctr_rdata;
  logic [CONF_BITS-1:0]  conf_cur;
  logic [CONF_BITS-1:0]  conf_in;
  logic                  conf_ld;

  logic [CONF_BITS-1:0]  m_mem [NSLOT];
  bit                    m_saved [NSLOT];
  bit                    m_valid [NSLOT];
  bit                    m_err;
  logic [CONF_BITS-1:0]  m_conf_in;
  bit                    m_conf_known;
  logic [DATA_W-1:0]     m_rdata;
  int                    n_cmp = 0;
  int                    n_fail = 0;

  always #5 clk = ~clk;

  xconf_mem_ctrl #(
    .CONF_BITS(CONF_BITS), .SLOT_W(SLOT_W), .CTR_ADDR_W(CTR_ADDR_W),
    .DATA_W(DATA_W), .CONF_MEM_BASE(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctr_valid(ctr_valid), .ctr_we(ctr_we),
    .ctr_addr(ctr_addr), .ctr_data_in(ctr_data_in), .ctr_ready(ctr_ready),
    .ctr_rdata(ctr_rdata), .conf_cur(conf_cur), .conf_in(conf_in), .conf_ld(conf_ld)
  );

  function automatic logic [CONF_BITS-1:0] rand_word();
    logic [CONF_BITS-1:0] w;
    for (int i = 0; i < CONF_BITS / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] exp_status();
    int v;
    v = 0;
    if (VEN) begin
      for (int i = 0; i < NSLOT; i++) if (m_valid[i]) v = v + (4 << i);
      if (m_err) v = v + 2;
    end
    return DATA_W'(v);
  endfunction

  // Presents one request in an idle cycle; returns at the falling edge after the accept edge.
  task automatic send(input logic we, input logic [CTR_ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
    ctr_valid = 1'b1; ctr_we = we; ctr_addr = addr; ctr_data_in = d;
    @(posedge clk);
    @(negedge clk);
    ctr_valid = 1'b0;
  endtask

  task automatic do_save(input logic [DATA_W-1:0] d, input logic [CONF_BITS-1:0] w);
    int s;
    s = int'(d) % NSLOT;
    conf_cur = w;
    send(1'b1, BASE, d);
    m_mem[s] = w; m_saved[s] = 1'b1;
    if (VEN) m_valid[s] = 1'b1;
    n_cmp++;
    if (ctr_ready !== 1'b1 || conf_ld !== 1'b0) begin
      n_fail++; $display("FAIL save_single_cycle: ready=%b ld=%b expected ready=1 ld=0", ctr_ready, conf_ld);
    end
  endtask

  task automatic do_load(input logic [DATA_W-1:0] d);
    int s;
    bit exp_ld;
    s = int'(d) % NSLOT;
    exp_ld = VEN ? m_valid[s] : 1'b1;
    send(1'b1, BASE + 10'd1, d);
    n_cmp++;
    if (ctr_ready !== 1'b0 || conf_ld !== 1'b0) begin
      n_fail++; $display("FAIL load_cycle1: ready=%b ld=%b expected ready=0 ld=0", ctr_ready, conf_ld);
    end
    @(negedge clk);
    n_cmp++;
    if (ctr_ready !== 1'b0 || conf_ld !== exp_ld) begin
      n_fail++; $display("FAIL load_cycle2 slot %0d: ready=%b ld=%b expected ready=0 ld=%b", s, ctr_ready, conf_ld, exp_ld);
    end
    if (exp_ld && m_saved[s]) begin
      n_cmp++;
      if (conf_in !== m_mem[s]) begin
        n_fail++; $display("FAIL load_data slot %0d: got %h expected %h", s, conf_in, m_mem[s]);
      end
    end
    if (exp_ld) begin
      m_conf_in = m_mem[s]; m_conf_known = m_saved[s];
    end else begin
      m_err = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (ctr_ready !== 1'b1 || conf_ld !== 1'b0) begin
      n_fail++; $display("FAIL load_done: ready=%b ld=%b expected ready=1 ld=0", ctr_ready, conf_ld);
    end
    if (m_conf_known) begin
      n_cmp++;
      if (conf_in !== m_conf_in) begin
        n_fail++; $display("FAIL conf_in_hold: got %h expected %h", conf_in, m_conf_in);
      end
    end
  endtask

  task automatic do_status();
    send(1'b0, BASE + 10'd3, DATA_W'($urandom()));
    m_rdata = exp_status();
    n_cmp++;
    if (ctr_rdata !== m_rdata) begin
      n_fail++; $display("FAIL status: got %h expected %h", ctr_rdata, m_rdata);
    end
  endtask

  task automatic do_clear();
    send(1'b1, BASE + 10'd2, DATA_W'($urandom()));
    if (VEN) begin
      for (int i = 0; i < NSLOT; i++) m_valid[i] = 1'b0;
      m_err = 1'b0;
    end
    n_cmp++;
    if (ctr_ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_single_cycle: ready=%b expected 1", ctr_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ctr_valid = 1'b0; ctr_we = 1'b0; ctr_addr = '0; ctr_data_in = '0; conf_cur = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (conf_ld !== 1'b0 || conf_in !== '0 || ctr_rdata !== '0 || ctr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_state: ld=%b conf_in=%h rdata=%h ready=%b expected 0/0/0/1", conf_ld, conf_in, ctr_rdata, ctr_ready);
    end
    rst_n = 1'b1;
    m_err = 1'b0; m_conf_in = '0; m_conf_known = 1'b1; m_rdata = '0;
    for (int i = 0; i < NSLOT; i++) begin m_valid[i] = 1'b0; m_saved[i] = 1'b0; end
    @(negedge clk);
    do_status();
  endtask

  task automatic test_save_load_basic();
    do_save(DATA_W'(3), {(CONF_BITS/8){8'hA5}});
    conf_cur = '0;
    do_load(DATA_W'(3));
  endtask

  task automatic test_dropped_during_busy();
    logic [CONF_BITS-1:0] p0;
    p0 = rand_word();
    do_save(DATA_W'(1), rand_word());
    do_clear();
    do_save(DATA_W'(0), p0);
    send(1'b1, BASE + 10'd1, DATA_W'(0));
    conf_cur = rand_word();
    ctr_valid = 1'b1; ctr_we = 1'b1; ctr_addr = BASE; ctr_data_in = DATA_W'(1);
    n_cmp++;
    if (ctr_ready !== 1'b0) begin
      n_fail++; $display("FAIL busy_ready: got %b expected 0", ctr_ready);
    end
    @(negedge clk);
    ctr_valid = 1'b0;
    n_cmp++;
    if (conf_ld !== 1'b1 || conf_in !== p0) begin
      n_fail++; $display("FAIL busy_load_out: ld=%b data=%h expected ld=1 data=%h", conf_ld, conf_in, p0);
    end
    m_conf_in = p0; m_conf_known = 1'b1;
    @(negedge clk);
    do_load(DATA_W'(1));
    do_status();
  endtask

  task automatic test_slot_wrap();
    do_save(DATA_W'(9), rand_word());
    conf_cur = rand_word();
    do_load(DATA_W'(1));
    do_save(DATA_W'(11'h7FE), rand_word());
    do_load(DATA_W'(6));
  endtask

  task automatic test_valid_bitmap();
    do_clear();
    do_save(DATA_W'(0), rand_word());
    do_save(DATA_W'(2), rand_word());
    do_status();
    do_clear();
    do_status();
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      int op;
      op = $urandom_range(0, 5);
      case (op)
        0, 1: do_save(DATA_W'($urandom()), rand_word());
        2: do_load(DATA_W'($urandom()));
        3: do_status();
        4: if ($urandom_range(0, 3) == 0) do_clear(); else do_status();
        default: begin
          int kind;
          logic [CTR_ADDR_W-1:0] a;
          kind = $urandom_range(0, 2);
          conf_cur = rand_word();
          if (kind == 0) begin
            a = CTR_ADDR_W'($urandom_range(0, 1023));
            while (a >= BASE && a <= BASE + 10'd3) a = CTR_ADDR_W'($urandom_range(0, 1023));
            send(1'($urandom()), a, DATA_W'($urandom()));
          end else if (kind == 1) begin
            send(1'b0, BASE + CTR_ADDR_W'($urandom_range(0, 2)), DATA_W'($urandom()));
          end else begin
            send(1'b1, BASE + 10'd3, DATA_W'($urandom()));
          end
          n_cmp++;
          if (ctr_ready !== 1'b1 || conf_ld !== 1'b0 || ctr_rdata !== m_rdata) begin
            n_fail++; $display("FAIL ignored_cmd kind %0d: ready=%b ld=%b rdata=%h expected 1/0/%h", kind, ctr_ready, conf_ld, ctr_rdata, m_rdata);
          end
        end
      endcase
    end
  endtask

  task automatic test_reset_abort();
    do_save(DATA_W'(5), rand_word());
    send(1'b1, BASE + 10'd1, DATA_W'(5));
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (conf_ld !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_ld cycle %0d: got %b expected 0", i, conf_ld);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < NSLOT; i++) m_valid[i] = 1'b0;
    m_err = 1'b0; m_conf_in = '0; m_conf_known = 1'b1; m_rdata = '0;
    @(negedge clk);
    n_cmp++;
    if (ctr_ready !== 1'b1 || conf_in !== '0 || conf_ld !== 1'b0) begin
      n_fail++; $display("FAIL abort_recover: ready=%b conf_in=%h ld=%b expected 1/0/0", ctr_ready, conf_in, conf_ld);
    end
    do_status();
    do_load(DATA_W'(5));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_save_load_basic();
    test_dropped_during_busy();
    test_slot_wrap();
    test_valid_bitmap();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
